rvc_fetch_aligner: RTL and testbench
====================================

# rvc_fetch_aligner

Sequences 32-bit fetch words into a stream of whole instructions for the core's compressed-instruction path. It handles every word layout: one full instruction, two compressed halves, half-plus-full, and full instructions split across two fetch words. It sits between the fetch unit and the compressed expansion/decode stage. It owns the halfword buffer, the instruction PC and the fetch/decode handshakes.

## Interface
- XLEN, 32, PC width
- RESET_PC, 32'h0000_0000, PC after reset (bit 0 ignored)
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- redirect_i  in  1  flush and restart at redirect_pc_i
- redirect_pc_i  in  XLEN  restart PC, bit 0 ignored
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  fetch word consumed this cycle
- fetch_word_i  in  32  word at PC with bits [1:0] cleared
- inst_valid_o  out  1  instruction valid
- inst_ready_i  in  1  decode accepts; low means stall
- inst_o  out  32  full instruction, or {16'h0, half} if compressed
- inst_pc_o  out  XLEN  PC of inst_o
- inst_compressed_o  out  1  inst_o is 16-bit
- inst_span_o  out  1  inst_o assembled from two fetch words

## Operation
- A halfword h is full-start when h[1:0]==2'b11; otherwise it is compressed.
- Internal state: buf_q (16b), pc_q (XLEN), FSM state.
- FSM states:
  - ALIGNED: buffer empty.
  - BUFFERED: buf_q holds the next instruction's first half.
  - SKIP_LOW: after a redirect to PC[1]=1.
- adv = !inst_valid_o || inst_ready_i. An instruction is emitted only when adv=1.
- ALIGNED, word accepted:
  - Low half full-start: emit the whole word at pc_q; pc_q += 4; stay in ALIGNED.
  - Low half compressed: emit the low half; buf_q <= upper half; pc_q += 2; go to BUFFERED.
- BUFFERED, buf_q compressed: emit buf_q with no fetch consumed (fetch_ready_o=0); pc_q += 2; go to ALIGNED.
- BUFFERED, buf_q full-start, word accepted: emit {word[15:0], buf_q} with span=1; buf_q <= word[31:16]; pc_q += 4; stay in BUFFERED.
- SKIP_LOW, word accepted: discard the low half; buf_q <= upper half; emit nothing; go to BUFFERED. pc_q is unchanged.
- fetch_ready_o:
  - ALIGNED: adv.
  - BUFFERED: adv && buf_q full-start.
  - SKIP_LOW: 1.
- Redirect has the highest priority:
  - pc_q <= {redirect_pc_i[XLEN-1:1], 0}.
  - State <= redirect_pc_i[1] ? SKIP_LOW : ALIGNED.
  - inst_valid_o <= 0.
  - fetch_ready_o=1 and any presented word is dropped.
- PC arithmetic is modulo 2^XLEN; wrap past all-ones is legal.

## Timing
- Reset values:
  - state ALIGNED, pc_q=RESET_PC, buf_q=0.
  - All outputs 0, except fetch_ready_o, which is 1 (ALIGNED with adv=1).
- Latency: a word accepted in cycle N gives inst_valid_o=1 in cycle N+1 (registered outputs).
- A second compressed half from the same word appears in cycle N+2 at full throughput.
- Under stall, inst_* holds stable until accepted, and no word is consumed.
- A redirect during a stall drops the held instruction. Reset mid-operation discards all state.

## Configuration
- RVC_SUPPORT_EN defined: full behaviour above.
- RVC_SUPPORT_EN undefined:
  - Buffer and SKIP_LOW/BUFFERED logic are removed; every word is emitted as 32-bit; pc_q += 4.
  - inst_compressed_o and inst_span_o are tied to 0.
  - redirect_pc_i[1] is ignored (treated as 0).

## Structure
- Package rvc_align_pkg holds:
  - state enum (ALIGNED, BUFFERED, SKIP_LOW).
  - half_t (logic [15:0]).
  - function is_full_start(half_t).
  - constants PC_INC_C=2, PC_INC_F=4.
- Sub-module rvc_align_out_reg: output holding register with the valid/ready (adv) logic.

## Test plan
- Reset, word 0x00000013 -> inst 0x00000013 at pc 0x0, compressed=0; next pc 0x4.
- Word 0x45014501 -> 0x00004501 at pc 0x0, then 0x00004501 at pc 0x2; fetch_ready_o=0 in the second cycle.
- Words 0x00134501, 0x45010000 -> 0x4501 at 0x0; 0x00000013 at 0x2 with span=1; 0x4501 at 0x6.
- Redirect to 0x102, words 0x0013ABCD, 0x45010000 -> ABCD dropped; 0x00000013 at 0x102 with span=1; 0x4501 at 0x106.
- inst_ready_i low for 3 cycles with a valid instruction -> inst_o/inst_pc_o stable, fetch_ready_o=0; resumes in order.
- Redirect during stall -> inst_valid_o=0 the next cycle; the first output comes from redirect_pc_i.

Source files
------------

// File: rtl/rvc_align_pkg.sv
// Shared types and helpers for the compressed-instruction fetch aligner.
package rvc_align_pkg;

  typedef enum logic [1:0] {
    ALIGNED  = 2'd0,
    BUFFERED = 2'd1,
    SKIP_LOW = 2'd2
  } state_e;

  typedef logic [15:0] half_t;

  localparam int unsigned PC_INC_C = 2;
  localparam int unsigned PC_INC_F = 4;

  // A halfword with both low bits set begins a 32-bit instruction.
  function automatic logic is_full_start(input half_t h);
    return (h[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/rvc_align_out_reg.sv
// Registered instruction output stage; holds data stable while decode stalls.
module rvc_align_out_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_comp,
  input  logic            i_span,
  output logic            o_adv,
  output logic            o_valid,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic            o_comp,
  output logic            o_span
);

  logic            r_valid;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_pc;
  logic            r_comp;
  logic            r_span;

  // The slot can take a new instruction when it is empty or being drained.
  assign o_adv = !r_valid || i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
      r_comp  <= 1'b0;
      r_span  <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_adv) begin
      r_valid <= i_load;
      if (i_load) begin
        r_inst <= i_inst;
        r_pc   <= i_pc;
        r_comp <= i_comp;
        r_span <= i_span;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_comp  = r_comp;
  assign o_span  = r_span;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Turns 32-bit fetch words into whole (16/32-bit) instructions with their PC.
// Compressed support is compiled in only when RVC_SUPPORT_EN is defined.
module rvc_fetch_aligner
  import rvc_align_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_word_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_compressed_o,
  output logic            inst_span_o
);

  localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[XLEN-1:1], 1'b0};
  localparam logic [XLEN-1:0] INC_F      = XLEN'(PC_INC_F);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_adv;
  logic            w_emit;
  logic [31:0]     w_inst;
  logic            w_comp;
  logic            w_span;
  logic            w_fetch_ready;

`ifdef RVC_SUPPORT_EN
  localparam logic [XLEN-1:0] INC_C = XLEN'(PC_INC_C);

  state_e r_state;
  state_e w_state_nxt;
  half_t  r_buf;
  half_t  w_buf_nxt;
  logic   w_unused_rpc;

  assign w_unused_rpc = redirect_pc_i[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ALIGNED;
      r_buf   <= '0;
      r_pc    <= RESET_PC_A;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_pc_nxt      = r_pc;
    w_emit        = 1'b0;
    w_inst        = fetch_word_i;
    w_comp        = 1'b0;
    w_span        = 1'b0;
    w_fetch_ready = 1'b0;
    if (redirect_i) begin
      w_fetch_ready = 1'b1;
      w_pc_nxt      = {redirect_pc_i[XLEN-1:1], 1'b0};
      w_state_nxt   = redirect_pc_i[1] ? SKIP_LOW : ALIGNED;
    end else begin
      case (r_state)
        ALIGNED: begin
          w_fetch_ready = w_adv;
          if (w_adv && fetch_valid_i) begin
            w_emit = 1'b1;
            if (is_full_start(fetch_word_i[15:0])) begin
              w_pc_nxt = r_pc + INC_F;
            end else begin
              w_inst      = {16'h0, fetch_word_i[15:0]};
              w_comp      = 1'b1;
              w_buf_nxt   = fetch_word_i[31:16];
              w_pc_nxt    = r_pc + INC_C;
              w_state_nxt = BUFFERED;
            end
          end
        end
        BUFFERED: begin
          if (!is_full_start(r_buf)) begin
            // Buffered compressed half drains without touching fetch.
            if (w_adv) begin
              w_emit      = 1'b1;
              w_inst      = {16'h0, r_buf};
              w_comp      = 1'b1;
              w_pc_nxt    = r_pc + INC_C;
              w_state_nxt = ALIGNED;
            end
          end else begin
            w_fetch_ready = w_adv;
            if (w_adv && fetch_valid_i) begin
              w_emit    = 1'b1;
              w_inst    = {fetch_word_i[15:0], r_buf};
              w_span    = 1'b1;
              w_buf_nxt = fetch_word_i[31:16];
              w_pc_nxt  = r_pc + INC_F;
            end
          end
        end
        SKIP_LOW: begin
          w_fetch_ready = 1'b1;
          if (fetch_valid_i) begin
            w_buf_nxt   = fetch_word_i[31:16];
            w_state_nxt = BUFFERED;
          end
        end
        default: w_state_nxt = ALIGNED;
      endcase
    end
  end
`else
  logic [1:0] w_unused_rpc;

  assign w_unused_rpc = redirect_pc_i[1:0];
  assign w_comp       = 1'b0;
  assign w_span       = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC_A;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  always_comb begin
    w_pc_nxt      = r_pc;
    w_emit        = 1'b0;
    w_inst        = fetch_word_i;
    w_fetch_ready = w_adv;
    if (redirect_i) begin
      w_fetch_ready = 1'b1;
      w_pc_nxt      = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (w_adv && fetch_valid_i) begin
      w_emit   = 1'b1;
      w_pc_nxt = r_pc + INC_F;
    end
  end
`endif

  assign fetch_ready_o = w_fetch_ready;

  rvc_align_out_reg #(
    .XLEN(XLEN)
  ) u_out_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .i_flush(redirect_i),
    .i_load (w_emit),
    .i_ready(inst_ready_i),
    .i_inst (w_inst),
    .i_pc   (r_pc),
    .i_comp (w_comp),
    .i_span (w_span),
    .o_adv  (w_adv),
    .o_valid(inst_valid_o),
    .o_inst (inst_o),
    .o_pc   (inst_pc_o),
    .o_comp (inst_compressed_o),
    .o_span (inst_span_o)
  );

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Bench for rvc_fetch_aligner: directed scenarios plus a halfword-queue scoreboard.
module tb_rvc_fetch_aligner;

  localparam int XLEN = 32;
`ifdef RVC_SUPPORT_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_word_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_compressed_o;
  logic        inst_span_o;

  int vectors    = 0;
  int miscompares = 0;

  rvc_fetch_aligner #(
    .XLEN(XLEN),
    .RESET_PC(32'h0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_ready_o    (fetch_ready_o),
    .fetch_word_i     (fetch_word_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_compressed_o(inst_compressed_o),
    .inst_span_o      (inst_span_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: consumed fetch words become a stream of addressed halfwords,
  // and instructions are carved off its head in program order.
  typedef struct {logic [15:0] h; logic [31:0] pc;} hw_t;
  typedef struct {logic [31:0] inst; logic [31:0] pc; logic comp; logic span;} ex_t;
  hw_t         hq[$];
  ex_t         eq[$];
  ex_t         e;
  logic [31:0] fa;
  logic        skip;
  logic        hold_prev;
  logic [66:0] held;

  always @(negedge clk) begin
    if (!reset_n) begin
      hq.delete();
      eq.delete();
      fa        = 32'h0;
      skip      = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        vectors++;
        if ({inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o} !== held) begin
          miscompares++;
          $display("FAIL stall_hold got %h exp %h",
                   {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o}, held);
        end
      end
      if (inst_valid_o && inst_ready_i) begin
        vectors++;
        if (eq.size() == 0) begin
          miscompares++;
          $display("FAIL accept_order got inst %h pc %h exp no instruction", inst_o, inst_pc_o);
        end else begin
          e = eq.pop_front();
          if ({inst_o, inst_pc_o, inst_compressed_o, inst_span_o} !== {e.inst, e.pc, e.comp, e.span}) begin
            miscompares++;
            $display("FAIL accept_data got inst %h pc %h c %b s %b exp inst %h pc %h c %b s %b",
                     inst_o, inst_pc_o, inst_compressed_o, inst_span_o, e.inst, e.pc, e.comp, e.span);
          end
        end
      end
      hold_prev = inst_valid_o && !inst_ready_i && !redirect_i;
      held      = {1'b1, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
      if (redirect_i) begin
        hq.delete();
        eq.delete();
        fa   = redirect_pc_i & ~32'h3;
        skip = RVC && redirect_pc_i[1];
      end else if (fetch_valid_i && fetch_ready_o) begin
        if (!RVC) begin
          eq.push_back('{fetch_word_i, fa, 1'b0, 1'b0});
        end else begin
          if (!skip) hq.push_back('{fetch_word_i[15:0], fa});
          hq.push_back('{fetch_word_i[31:16], fa + 32'd2});
          skip = 1'b0;
        end
        fa = fa + 32'd4;
      end
      while (hq.size() > 0) begin
        if (hq[0].h[1:0] != 2'b11) begin
          eq.push_back('{{16'h0, hq[0].h}, hq[0].pc, 1'b1, 1'b0});
          void'(hq.pop_front());
        end else if (hq.size() >= 2) begin
          eq.push_back('{{hq[1].h, hq[0].h}, hq[0].pc, 1'b0, hq[0].pc[1]});
          void'(hq.pop_front());
          void'(hq.pop_front());
        end else begin
          break;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    fetch_valid_i = 1'b0;
    inst_ready_i  = 1'b1;
    tick();
    redirect_i = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [15:0] lo, hi;
    lo = 16'($urandom);
    hi = 16'($urandom);
    if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
    return {hi, lo};
  endfunction

  task automatic test_reset();
    reset_n       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    fetch_valid_i = 1'b0;
    fetch_word_i  = 32'h0;
    inst_ready_i  = 1'b1;
    #2;
    vectors++;
    if ({inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o} !== 67'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp 0",
               {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o});
    end
    vectors++;
    if (fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_fetch_ready got %b exp 1", fetch_ready_o);
    end
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    vectors++;
    if (inst_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_valid got %b exp 0", inst_valid_o);
    end
  endtask

  task automatic test_full_word();
    logic [66:0] got_v;
    fetch_word_i  = 32'h0000_0013;
    fetch_valid_i = 1'b1;
    #1;
    vectors++;
    if (fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL full_ready got %b exp 1", fetch_ready_o);
    end
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    vectors++;
    if (got_v !== {1'b1, 32'h13, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL full_first got %h exp %h", got_v, {1'b1, 32'h13, 32'h0, 1'b0, 1'b0});
    end
    fetch_word_i  = 32'h0000_0093;
    fetch_valid_i = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    vectors++;
    if (got_v !== {1'b1, 32'h93, 32'h4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL full_next_pc got %h exp %h", got_v, {1'b1, 32'h93, 32'h4, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_two_compressed();
    logic [66:0] got_v, exp_v;
    flush_to(32'h0);
    fetch_word_i  = 32'h4501_4501;
    fetch_valid_i = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    exp_v = RVC ? {1'b1, 32'h4501, 32'h0, 1'b1, 1'b0} : {1'b1, 32'h4501_4501, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL cc_first got %h exp %h", got_v, exp_v);
    end
    vectors++;
    if (fetch_ready_o !== !RVC) begin
      miscompares++;
      $display("FAIL cc_fetch_ready got %b exp %b", fetch_ready_o, !RVC);
    end
    tick();
    got_v = inst_valid_o ? {1'b1, inst_o, inst_pc_o, inst_compressed_o, inst_span_o} : 67'h0;
    exp_v = RVC ? {1'b1, 32'h4501, 32'h2, 1'b1, 1'b0} : 67'h0;
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL cc_second got %h exp %h", got_v, exp_v);
    end
    tick();
  endtask

  task automatic test_span();
    logic [66:0] got_v, exp_v;
    flush_to(32'h0);
    fetch_word_i  = 32'h0013_4501;
    fetch_valid_i = 1'b1;
    tick();
    fetch_word_i = 32'h4501_0000;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    exp_v = RVC ? {1'b1, 32'h4501, 32'h0, 1'b1, 1'b0} : {1'b1, 32'h0013_4501, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL span_first got %h exp %h", got_v, exp_v);
    end
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    exp_v = RVC ? {1'b1, 32'h13, 32'h2, 1'b0, 1'b1} : {1'b1, 32'h4501_0000, 32'h4, 1'b0, 1'b0};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL span_joined got %h exp %h", got_v, exp_v);
    end
    tick();
    got_v = inst_valid_o ? {1'b1, inst_o, inst_pc_o, inst_compressed_o, inst_span_o} : 67'h0;
    exp_v = RVC ? {1'b1, 32'h4501, 32'h6, 1'b1, 1'b0} : 67'h0;
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL span_tail got %h exp %h", got_v, exp_v);
    end
    tick();
  endtask

  task automatic test_redirect_odd();
    logic [66:0] got_v, exp_v;
    flush_to(32'h102);
    fetch_word_i  = 32'h0013_ABCD;
    fetch_valid_i = 1'b1;
    #1;
    vectors++;
    if (fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL odd_ready got %b exp 1", fetch_ready_o);
    end
    tick();
    fetch_word_i = 32'h4501_0000;
    #1;
    got_v = inst_valid_o ? {1'b1, inst_o, inst_pc_o, inst_compressed_o, inst_span_o} : 67'h0;
    exp_v = RVC ? 67'h0 : {1'b1, 32'h0013_ABCD, 32'h100, 1'b0, 1'b0};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL odd_skip got %h exp %h", got_v, exp_v);
    end
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    exp_v = RVC ? {1'b1, 32'h13, 32'h102, 1'b0, 1'b1} : {1'b1, 32'h4501_0000, 32'h104, 1'b0, 1'b0};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL odd_span got %h exp %h", got_v, exp_v);
    end
    tick();
    got_v = inst_valid_o ? {1'b1, inst_o, inst_pc_o, inst_compressed_o, inst_span_o} : 67'h0;
    exp_v = RVC ? {1'b1, 32'h4501, 32'h106, 1'b1, 1'b0} : 67'h0;
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL odd_tail got %h exp %h", got_v, exp_v);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [66:0] got_v;
    flush_to(32'h0);
    inst_ready_i  = 1'b0;
    fetch_word_i  = 32'h0000_0013;
    fetch_valid_i = 1'b1;
    tick();
    fetch_word_i = 32'h0000_0093;
    for (int i = 0; i < 3; i++) begin
      #1;
      got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
      vectors++;
      if (got_v !== {1'b1, 32'h13, 32'h0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_data got %h exp %h", got_v, {1'b1, 32'h13, 32'h0, 1'b0, 1'b0});
      end
      vectors++;
      if (fetch_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_fetch_ready got %b exp 0", fetch_ready_o);
      end
      tick();
    end
    inst_ready_i = 1'b1;
    #1;
    vectors++;
    if (fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_resume_ready got %b exp 1", fetch_ready_o);
    end
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    vectors++;
    if (got_v !== {1'b1, 32'h93, 32'h4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_resume got %h exp %h", got_v, {1'b1, 32'h93, 32'h4, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_redirect_stall();
    logic [66:0] got_v;
    flush_to(32'h0);
    inst_ready_i  = 1'b0;
    fetch_word_i  = 32'h0000_0013;
    fetch_valid_i = 1'b1;
    tick();
    fetch_word_i  = 32'h0000_0093;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    #1;
    vectors++;
    if (fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstall_ready got %b exp 1", fetch_ready_o);
    end
    tick();
    redirect_i    = 1'b0;
    fetch_valid_i = 1'b0;
    #1;
    vectors++;
    if (inst_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstall_drop got %b exp 0", inst_valid_o);
    end
    inst_ready_i  = 1'b1;
    fetch_valid_i = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    vectors++;
    if (got_v !== {1'b1, 32'h93, 32'h200, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rstall_restart got %h exp %h", got_v, {1'b1, 32'h93, 32'h200, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      redirect_i    = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       redirect_pc_i = 32'hFFFF_FFFE;
        1:       redirect_pc_i = 32'hFFFF_FFFC;
        2:       redirect_pc_i = 32'hFFFF_FFFF;
        default: redirect_pc_i = $urandom;
      endcase
      fetch_valid_i = ($urandom_range(0, 9) < 7);
      fetch_word_i  = rnd_word();
      inst_ready_i  = ($urandom_range(0, 9) < 7);
      tick();
    end
    redirect_i    = 1'b0;
    fetch_valid_i = 1'b0;
  endtask

  task automatic test_drain();
    redirect_i    = 1'b0;
    fetch_valid_i = 1'b0;
    inst_ready_i  = 1'b1;
    repeat (8) tick();
    vectors++;
    if (eq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_pending got %0d instructions left exp 0", eq.size());
    end
    vectors++;
    if (inst_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_valid got %b exp 0", inst_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [66:0] got_v;
    test_random(25);
    reset_n       = 1'b0;
    inst_ready_i  = 1'b1;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    vectors++;
    if (got_v !== 67'h0 || fetch_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_outputs got %h ready %b exp 0 ready 1", got_v, fetch_ready_o);
    end
    tick();
    tick();
    reset_n       = 1'b1;
    fetch_word_i  = 32'h0000_0013;
    fetch_valid_i = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
    #1;
    got_v = {inst_valid_o, inst_o, inst_pc_o, inst_compressed_o, inst_span_o};
    vectors++;
    if (got_v !== {1'b1, 32'h13, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_restart got %h exp %h", got_v, {1'b1, 32'h13, 32'h0, 1'b0, 1'b0});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_two_compressed();
    test_span();
    test_redirect_odd();
    test_stall();
    test_redirect_stall();
    test_random(2000);
    test_drain();
    test_reset_mid();
    test_random(1000);
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
